// File: rtl/match_event_counter.sv
// Counts rising edges of a sequence detector's match output and raises a sticky alert at a threshold.
// Optional gap timer reporting spacing between the last two matches: define MATCH_CNT_GAP_EN.
module match_event_counter #(
   parameter int unsigned CW = 8,
   parameter int unsigned GW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          match,
   input  logic [CW-1:0] thresh,
   input  logic          ack,
   output logic [CW-1:0] count,
   output logic          alert,
   output logic          overflow,
   output logic [GW-1:0] last_gap
);

   typedef enum logic [1:0] {IDLE, COUNT, ALERT} state_t;

   state_t        state, state_nx;
   logic          match_d;
   logic          rise;
   logic          active;
   logic          start;
   logic          clr_ack;
   logic [CW-1:0] count_base;
   logic          count_max;
   logic [CW-1:0] count_nx;
   logic          hit;

   assign rise    = match & ~match_d;
   assign active  = (state != IDLE) && en;
   assign start   = (state == IDLE) && en;
   assign clr_ack = active && (state == ALERT) && ack;

   // An ack clears the count first, so an edge in the same cycle lands on 1.
   assign count_base = clr_ack ? '0 : count;
   assign count_max  = &count_base;
   assign count_nx   = (rise && !count_max) ? count_base + 1'b1 : count_base;
   assign hit        = rise && (thresh != '0) && (count_nx == thresh);

   assign alert = (state == ALERT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (en) state_nx = COUNT;
         COUNT:   if (!en) state_nx = IDLE;
                  else if (hit) state_nx = ALERT;
         ALERT:   if (!en) state_nx = IDLE;
                  else if (clr_ack) state_nx = hit ? ALERT : COUNT;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match_d  <= 1'b0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         match_d <= match;
         if (start) begin
            count    <= '0;
            overflow <= 1'b0;
         end else if (active) begin
            count    <= count_nx;
            overflow <= (overflow && !clr_ack) || (rise && count_max);
         end
      end
   end

`ifdef MATCH_CNT_GAP_EN
   logic [GW-1:0] gap_cnt;
   logic [GW-1:0] gap_inc;

   assign gap_inc = (&gap_cnt) ? gap_cnt : gap_cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_cnt  <= '0;
         last_gap <= '0;
      end else if (start) begin
         gap_cnt <= '0;
      end else if (active) begin
         if (rise) begin
            last_gap <= gap_inc;
            gap_cnt  <= '0;
         end else begin
            gap_cnt <= gap_inc;
         end
      end
   end
`else
   assign last_gap = '0;
`endif

endmodule

// File: tb/tb_match_event_counter.sv
// Randomized plus directed bench for match_event_counter against an arithmetic reference model.
// Gap expectations follow MATCH_CNT_GAP_EN when it is defined for the build.
module tb_match_event_counter;

   localparam int unsigned CW = 8;
   localparam int unsigned GW = 8;
   localparam int MAXC = (1 << CW) - 1;
   localparam int MAXG = (1 << GW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          match = 1'b0;
   logic [CW-1:0] thresh = '0;
   logic          ack = 1'b0;
   logic [CW-1:0] count;
   logic          alert;
   logic          overflow;
   logic [GW-1:0] last_gap;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state: mode 0 idle, 1 counting, 2 alerting
   int m_mode, m_cnt, m_gap, m_last;
   bit m_prev, m_ovf;

   match_event_counter #(.CW(CW), .GW(GW)) dut (
      .clk(clk), .rst(rst), .en(en), .match(match), .thresh(thresh), .ack(ack),
      .count(count), .alert(alert), .overflow(overflow), .last_gap(last_gap)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_gap = 0; m_last = 0; m_prev = 0; m_ovf = 0;
   endtask

   task automatic model_step(input bit e_in, input bit m_in, input bit a_in, input int t_in);
      bit e;
      e = m_in && !m_prev;
      m_prev = m_in;
      if (m_mode == 0) begin
         if (e_in) begin
            m_mode = 1; m_cnt = 0; m_ovf = 0; m_gap = 0;
         end
      end else if (!e_in) begin
         m_mode = 0;
      end else begin
         if (m_mode == 2 && a_in) begin
            m_cnt = 0; m_ovf = 0; m_mode = 1;
         end
         if (e) begin
            if (m_cnt == MAXC) m_ovf = 1;
            else m_cnt = m_cnt + 1;
            if (t_in != 0 && m_cnt == t_in) m_mode = 2;
            m_last = (m_gap + 1 > MAXG) ? MAXG : m_gap + 1;
            m_gap = 0;
         end else begin
            m_gap = (m_gap + 1 > MAXG) ? MAXG : m_gap + 1;
         end
      end
   endtask

   task automatic check_outputs();
      int exp_gap;
`ifdef MATCH_CNT_GAP_EN
      exp_gap = m_last;
`else
      exp_gap = 0;
`endif
      check("count", 32'(count), 32'(m_cnt));
      check("alert", 32'(alert), 32'(m_mode == 2));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("last_gap", 32'(last_gap), 32'(exp_gap));
   endtask

   // inputs are applied at the falling edge; the model advances on the rising edge
   task automatic tick(input bit e_v, input bit m_v, input bit a_v, input int t_v);
      en = e_v; match = m_v; ack = a_v; thresh = CW'(t_v);
      @(posedge clk);
      model_step(e_v, m_v, a_v, t_v);
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      check_outputs();
      rst = 1'b0;

      for (int i = 0; i < 6; i++) tick(0, i[0], 0, 0);

      // threshold 3, pulses five cycles apart
      tick(1, 0, 0, 3);
      for (int p = 0; p < 3; p++) begin
         tick(1, 1, 0, 3);
         for (int i = 0; i < 4; i++) tick(1, 0, 0, 3);
      end
      check("alert_at_thresh", 32'(alert), 32'd1);

      // clear, then a held level counting once and an ack colliding with an edge
      tick(1, 0, 1, 1);
      for (int i = 0; i < 4; i++) tick(1, 1, 0, 1);
      tick(1, 0, 0, 1);
      tick(1, 1, 1, 1);
      check("ack_edge_count", 32'(count), 32'd1);
      check("ack_edge_alert", 32'(alert), 32'd1);

      // saturation with alert disabled
      tick(1, 0, 1, 0);
      for (int i = 0; i < 260; i++) begin
         tick(1, 1, 0, 0);
         tick(1, 0, 0, 0);
      end
      check("sat_count", 32'(count), 32'(MAXC));
      check("sat_overflow", 32'(overflow), 32'd1);
      tick(0, 0, 0, 0);
      tick(1, 0, 0, 0);
      tick(1, 0, 0, 0);
      check("reenable_count", 32'(count), 32'd0);

      // edges far apart saturate the gap timer
      for (int p = 0; p < 2; p++) begin
         tick(1, 1, 0, 0);
         for (int i = 0; i < 299; i++) tick(1, 0, 0, 0);
      end
      tick(1, 1, 0, 0);
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);

      // randomized operation
      thresh = CW'($urandom_range(0, 4));
      for (int i = 0; i < 2500; i++) begin
         int t;
         t = int'(thresh);
         if ($urandom_range(0, 15) == 0) t = $urandom_range(0, 5);
         tick($urandom_range(0, 24) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 7) == 0, t);
      end

      // async reset while alerting
      tick(0, 0, 0, 1);
      tick(1, 0, 0, 1);
      tick(1, 0, 0, 1);
      tick(1, 1, 0, 1);
      check("pre_reset_alert", 32'(alert), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_alert", 32'(alert), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_last_gap", 32'(last_gap), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) tick(1, i[1], 0, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/match_event_counter.md
# match_event_counter

Downstream consumer of the Moore 11011 sequence detector. It takes the detector's one-bit `out` as `match`, counts match events (rising edges), and raises a sticky `alert` when a programmable threshold is reached. Software acknowledges the alert with `ack`. An optional gap timer reports the spacing, in cycles, between the two most recent matches.

## Interface
- `CW`, default 8: width of event count and threshold.
- `GW`, default 8: width of gap timer and `last_gap`.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous reset, active-high.
- `en` input 1: count enable; low forces IDLE.
- `match` input 1: detector output, sampled every `clk`.
- `thresh` input CW: alert threshold; 0 disables alert.
- `ack` input 1: one-cycle alert acknowledge.
- `count` output CW: match events since last clear.
- `alert` output 1: high while in ALERT.
- `overflow` output 1: sticky; count saturated.
- `last_gap` output GW: cycles between the last two match edges.

## Operation
- Edge detect:
  - `match_d` registered copy of `match`; reset 0.
  - `edge = match & ~match_d`.
  - A level held high counts once.
- FSM states IDLE, COUNT, ALERT. Reset enters IDLE.
- IDLE:
  - `count`, `overflow`, `last_gap` held.
  - `alert` = 0.
  - `en`=1 → COUNT; on that transition, `count`, `overflow`, gap timer cleared to 0.
- COUNT:
  - On `edge`, `count` increments, saturating at 2^CW-1.
  - An `edge` while `count` = 2^CW-1 sets `overflow`.
  - If post-update count == `thresh` and `thresh` ≠ 0 → ALERT.
- ALERT:
  - Counting continues with the same saturation rules.
  - `ack`=1 → `count` cleared, `overflow` cleared, → COUNT.
  - `ack` together with `edge`: count becomes 1. If `thresh`==1, remain in ALERT.
- `en`=0 in COUNT or ALERT → IDLE next cycle; the edge in that cycle is not counted.
- `ack` outside ALERT is ignored.
- Gap timer (`gap_cnt`, GW bits, internal):
  - Each COUNT/ALERT cycle without edge: `gap_cnt` ← sat(`gap_cnt`+1).
  - On edge: `last_gap` ← sat(`gap_cnt`+1) and `gap_cnt` ← 0.
  - `last_gap` therefore equals t_edge − t_prev_edge. The first edge after COUNT entry measures from entry.
  - Saturation value is 2^GW-1.
  - Timer is frozen in IDLE.

## Timing
- Reset values: `count`=0, `alert`=0, `overflow`=0, `last_gap`=0, FSM=IDLE, `match_d`=0, `gap_cnt`=0.
- All outputs are registered. An edge sampled at clock k is visible on `count`/`last_gap` after clock k.
- `alert` rises in the same cycle the threshold count becomes visible.
- `ack` sampled at clock k: `alert` and `count` are low/0 after clock k.
- `en` rising sampled at clock k: COUNT after clock k; an edge at clock k+1 is counted.
- Async `rst` mid-operation immediately forces all reset values. The first post-reset edge requires `match`=1 after `match_d`=0.
- `thresh` may change at any time. Compare uses the current value; crossing past a lowered threshold does not alert.
- Detector back-to-back overlapping matches (every 3 cycles) each count.

## Configuration
- Macro `MATCH_CNT_GAP_EN`.
- Defined: gap timer and `last_gap` are implemented as above.
- Undefined: no gap logic; `last_gap` is tied to 0. Count, alert and overflow behaviour are unchanged.

## Test plan
- Reset then idle: `rst`=1 for 10 ns, `en`=0, `match` toggling → `count`=0, `alert`=0, `last_gap`=0 throughout.
- Threshold alert: `en`=1, `thresh`=3, three single-cycle `match` pulses 5 cycles apart → `count` 1, 2, 3; `alert`=1 after the third; `last_gap`=5 (with `MATCH_CNT_GAP_EN`).
- Level hold and ack collision:
  - Setup: `thresh`=1; `match` high for 4 cycles → `count`=1, `alert`=1.
  - Then `ack` in the same cycle as a new edge → `count`=1, `alert` stays 1.
- Saturation: `CW`=8, `thresh`=0, 260 edges → `count`=255, `overflow`=1, `alert`=0; `en` low then high → `count`=0, `overflow`=0.
- Gap saturation and disable: edges 300 cycles apart with `GW`=8 → `last_gap`=255. Deassert `en` in the same cycle as an edge → edge not counted, FSM IDLE.
- Async reset mid-ALERT: assert `rst` between clock edges → `alert`, `count`, `overflow`, `last_gap` = 0 immediately.
